// File: rtl/max_unpooling_pkg.sv
// rtl/max_unpooling_pkg.sv - state encodings and counter-width helper for streaming blocks
package max_unpooling_pkg;

  typedef enum logic [1:0] {
    ST_PASS   = 2'd0,
    ST_DUP    = 2'd1,
    ST_REPLAY = 2'd2
  } unpool_state_t;

  // Width of a counter covering 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/max_unpooling_row_buf.sv
// rtl/max_unpooling_row_buf.sv - one-row 1-bit line buffer, sync write, async read
module unpool_row_buf
  import max_unpooling_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int AW    = cnt_w(WIDTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic          i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic          o_rdata
);

  // Depth rounded to the full address range so every address decodes to a real entry.
  logic r_mem [0:(1<<AW)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/max_unpooling.sv
// rtl/max_unpooling.sv - 2x nearest-neighbour up-sampler for a serial 1-bit pixel stream
// Each input pixel is emitted twice, then the buffered row is replayed once to form the 2x2 block.
module max_unpooling
  import max_unpooling_pkg::*;
#(
  parameter int WIDTH  = 13,
  parameter int HEIGHT = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic pixel_in,
  input  logic valid_in,
  output logic ready_in,
  output logic pixel_out,
  output logic valid_out,
  input  logic ready_out,
  output logic last_out
);

  localparam int CW = cnt_w(WIDTH);
  localparam int RW = cnt_w(HEIGHT);
  localparam int QW = cnt_w(2 * WIDTH);
  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
  localparam logic [QW-1:0] RCNT_LAST = QW'(2 * WIDTH - 1);

  unpool_state_t r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [QW-1:0] r_rcnt;
  logic          r_pix;
  logic          r_valid;
  logic          r_last;

  logic          w_slot_free;
  logic          w_take;
  logic [CW-1:0] w_raddr;
  logic          w_rdata;

  assign w_slot_free = !r_valid || ready_out;
  // Held low during reset so nothing is accepted before the FSM is live.
  assign ready_in    = !rst && (r_state == ST_PASS) && w_slot_free;
  assign w_take      = valid_in && ready_in;
  assign w_raddr     = CW'(r_rcnt >> 1);

  unpool_row_buf #(
    .WIDTH (WIDTH),
    .AW    (CW)
  ) u_row_buf (
    .i_clk   (clk),
    .i_we    (w_take),
    .i_waddr (r_col),
    .i_wdata (pixel_in),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_PASS;
      r_col   <= '0;
      r_row   <= '0;
      r_rcnt  <= '0;
      r_pix   <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_PASS: begin
          if (w_take) begin
            r_pix   <= pixel_in;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_state <= ST_DUP;
          end else if (w_slot_free) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
          end
        end
        ST_DUP: begin
          if (w_slot_free) begin
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            if (r_col == COL_LAST) begin
              r_col   <= '0;
              r_rcnt  <= '0;
              r_state <= ST_REPLAY;
            end else begin
              r_col   <= r_col + CW'(1);
              r_state <= ST_PASS;
            end
          end
        end
        ST_REPLAY: begin
          if (w_slot_free) begin
            r_pix   <= w_rdata;
            r_valid <= 1'b1;
            if (r_rcnt == RCNT_LAST) begin
              r_rcnt  <= '0;
              r_state <= ST_PASS;
              if (r_row == ROW_LAST) begin
                r_last <= 1'b1;
                r_row  <= '0;
              end else begin
                r_last <= 1'b0;
                r_row  <= r_row + RW'(1);
              end
            end else begin
              r_rcnt <= r_rcnt + QW'(1);
              r_last <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_PASS;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign pixel_out = r_pix;
  assign valid_out = r_valid;
  assign last_out  = r_last;

endmodule
